fairy_muldiv_unit: RTL and testbench
====================================

// Module: fairy_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit for the execute stage. It replaces the single-cycle
//   combinational multiplier with a parametrised multi-cycle engine covering MULT, MULTU,
//   DIV and DIVU. It feeds HI/LO through a start/busy/valid handshake, and an
//   exception/eret flush can cancel it mid-operation.
// PARAMETERS
//   WIDTH      32  operand width; product and {rem,quot} are 2*WIDTH bits
//   CNT_W       6  iteration counter width, >= clog2(WIDTH)+1
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high reset
//   flush_i        in   1      exception|eret cancel; same priority as reset except outputs
//   start_i        in   1      launch op; accepted only when busy_o==0
//   op_i           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start_i)
//   a_i            in   WIDTH  rs operand (multiplicand / dividend)
//   b_i            in   WIDTH  rt operand (multiplier / divisor)
//   busy_o         out  1      engine occupied (states CALC, FIX)
//   valid_o        out  1      one-cycle pulse: hi_o/lo_o/div_by_zero_o are new
//   hi_o           out  WIDTH  product[2W-1:W] or remainder
//   lo_o           out  WIDTH  product[W-1:0] or quotient
//   div_by_zero_o  out  1      divide with b_i==0; valid only with valid_o
// BEHAVIOUR
//   - Reset: state IDLE, busy_o=0, valid_o=0, hi_o=0, lo_o=0, div_by_zero_o=0, counter=0.
//   - FSM: IDLE -(start_i & ~flush_i)-> CALC -(last iteration)-> FIX -> DONE -> IDLE.
//     DONE lasts 1 cycle with valid_o=1. start_i in DONE is accepted (busy_o=0) -> CALC.
//   - Accept edge: latch op and sign flags; latch |a|,|b| for signed ops and raw operands
//     for unsigned ops; counter=WIDTH.
//   - CALC, 1 iteration/cycle:
//       mul = radix-2 shift-add, LSB first, 2W accumulator.
//       div = restoring: shift {rem,quot} left, subtract divisor, set quotient bit if
//       no borrow.
//   - FIX: negate the product if sign(a)^sign(b) (signed MULT). For signed DIV, negate
//     the quotient if signs differ; the remainder takes the sign of the dividend.
//   - Latency: valid_o is high in cycle T+WIDTH+2 when start is accepted in cycle T.
//   - hi_o/lo_o/div_by_zero_o update only at DONE and hold until the next DONE;
//     busy_o=0 while IDLE/DONE.
//   - Arithmetic: all ops modulo 2^(2W).
//       Signed DIV of -2^(W-1) by -1: lo=-2^(W-1) (0x80000000 at W=32), hi=0,
//       div_by_zero_o=0.
//   - Divide by zero (b==0, DIV or DIVU): full latency; hi_o=a_i as presented,
//     lo_o={WIDTH{1'b1}}, no sign fix, div_by_zero_o=1.
//   - start_i while busy_o=1: ignored, no effect on the running op.
//   - flush_i: in any state -> IDLE next edge, busy_o=0, valid_o=0, outputs hold old
//     values. start_i and flush_i together: the start is dropped.
//   - reset overrides flush_i and start_i in the same cycle.
// CONFIGURATION
//   FAIRY_MULDIV_EARLY_OUT_EN
//     defined:   MULT/MULTU leave CALC after the iteration in which the remaining
//                multiplier magnitude becomes 0, minimum 1 CALC cycle.
//                Latency = 2 + max(1, bitlen(|b|)) cycles; results are identical.
//                DIV/DIVU are unchanged at WIDTH+2.
//     undefined: every op takes exactly WIDTH+2 cycles.
// TESTING (WIDTH=32)
//   MULT a=0xFFFFFFFF(-1), b=7 -> valid_o at T+34 (T+5 with EARLY_OUT),
//     hi=0xFFFFFFFF, lo=0xFFFFFFF9.
//   MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, latency 34
//     in both builds.
//   DIV a=-7, b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1);
//     DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, div_by_zero_o=1.
//   DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero_o=0.
//   Start DIVU, flush_i at T+10 -> busy_o=0 at T+11, no valid_o pulse;
//     hi/lo keep prior values; new start then completes normally.
//   Back-to-back: start at T, a second start at T+5 ignored;
//     start asserted in the DONE cycle is accepted, valid_o again 34 cycles later.

Source files
------------

// File: rtl/fairy_muldiv_unit.sv
// fairy_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with start/busy/valid handshake
// and flush cancel. Multiply is radix-2 shift-add; divide is restoring, one bit per cycle.
// Optional build macro FAIRY_MULDIV_EARLY_OUT_EN: multiplies leave CALC as soon as the
// remaining multiplier magnitude reaches zero (results unchanged, latency shorter).
module fairy_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             sign_a_q, sign_b_q, dbz_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] opb_q;   // multiplier (shifts right) or divisor
    logic [W2-1:0]    sh_q;    // multiplicand, shifts left each iteration
    logic [W2-1:0]    acc_q;   // product accumulator or {rem, quot}

    logic             accept_c, last_iter_c;
    logic             in_sa_c, in_sb_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c, mplier_next_c;
    logic [W2-1:0]    acc_mul_c, acc_div_c, prod_fix_c;
    logic [WIDTH:0]   rem_sh_c, diff_c;
    logic [WIDTH-1:0] quot_fix_c, rem_fix_c, res_hi_c, res_lo_c;

    assign accept_c = start_i & ~flush_i & ((state_q == S_IDLE) | (state_q == S_DONE));

    // Operand magnitudes for the accept edge
    always_comb begin
        in_sa_c = ~op_i[0] & a_i[WIDTH-1];
        in_sb_c = ~op_i[0] & b_i[WIDTH-1];
        mag_a_c = in_sa_c ? (WIDTH'(0) - a_i) : a_i;
        mag_b_c = in_sb_c ? (WIDTH'(0) - b_i) : b_i;
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mplier_next_c = opb_q >> 1;
        acc_mul_c     = opb_q[0] ? (acc_q + sh_q) : acc_q;
        rem_sh_c      = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        diff_c        = rem_sh_c - {1'b0, opb_q};
        if (!diff_c[WIDTH])
            acc_div_c = {diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            acc_div_c = {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
`ifdef FAIRY_MULDIV_EARLY_OUT_EN
        last_iter_c = (cnt_q == CNT_W'(1)) | (~op_q[1] & (mplier_next_c == WIDTH'(0)));
`else
        last_iter_c = (cnt_q == CNT_W'(1));
`endif
    end

    // Sign fix and divide-by-zero override, presented while in FIX
    always_comb begin
        prod_fix_c = (~op_q[0] & (sign_a_q ^ sign_b_q)) ? (W2'(0) - acc_q) : acc_q;
        quot_fix_c = (~op_q[0] & (sign_a_q ^ sign_b_q)) ? (WIDTH'(0) - acc_q[WIDTH-1:0])
                                                         : acc_q[WIDTH-1:0];
        rem_fix_c  = (~op_q[0] & sign_a_q) ? (WIDTH'(0) - acc_q[W2-1:WIDTH])
                                           : acc_q[W2-1:WIDTH];
        if (!op_q[1]) begin
            res_hi_c = prod_fix_c[W2-1:WIDTH];
            res_lo_c = prod_fix_c[WIDTH-1:0];
        end else if (dbz_q) begin
            res_hi_c = a_raw_q;
            res_lo_c = {WIDTH{1'b1}};
        end else begin
            res_hi_c = rem_fix_c;
            res_lo_c = quot_fix_c;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = S_CALC;
                S_CALC:  if (last_iter_c) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = start_i ? S_CALC : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath: operand capture on accept, one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            a_raw_q  <= '0;
            opb_q    <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
        end else if (accept_c) begin
            cnt_q    <= CNT_W'(WIDTH);
            op_q     <= op_i;
            sign_a_q <= in_sa_c;
            sign_b_q <= in_sb_c;
            dbz_q    <= op_i[1] & (b_i == WIDTH'(0));
            a_raw_q  <= a_i;
            opb_q    <= mag_b_c;
            sh_q     <= {WIDTH'(0), mag_a_c};
            acc_q    <= op_i[1] ? {WIDTH'(0), mag_a_c} : W2'(0);
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (op_q[1]) begin
                acc_q <= acc_div_c;
            end else begin
                acc_q <= acc_mul_c;
                sh_q  <= sh_q << 1;
                opb_q <= mplier_next_c;
            end
        end
    end

    // Registered handshake and result outputs; results load on the FIX->DONE edge
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_o        <= 1'b0;
            valid_o       <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            busy_o  <= (state_d == S_CALC) | (state_d == S_FIX);
            valid_o <= (state_d == S_DONE);
            if ((state_q == S_FIX) && (state_d == S_DONE)) begin
                hi_o          <= res_hi_c;
                lo_o          <= res_lo_c;
                div_by_zero_o <= op_q[1] & dbz_q;
            end
        end
    end

endmodule

// File: tb/tb_fairy_muldiv_unit.sv
// Self-checking bench for fairy_muldiv_unit (WIDTH=32): transaction-level reference model
// plus directed literal cases and randomized traffic with flush and reset.
module tb_fairy_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush_i, start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, valid_o, div_by_zero_o;
    logic [31:0] hi_o, lo_o;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic        m_busy, m_valid, m_dbz, p_dbz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    fairy_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .valid_o(valid_o), .hi_o(hi_o),
        .lo_o(lo_o), .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Architectural result and latency of one operation
    function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo,
                                     output logic dbz, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p, ua, ub;
        logic [31:0] mb;
        int          bl;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        dbz = 1'b0;
        lat = 34;
        hi  = '0;
        lo  = '0;
        case (op)
            2'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = ua * ub;      hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (op == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    hi = r[31:0]; lo = q[31:0];
                end else begin
                    p = ua / ub; hi = 32'(ua % ub); lo = p[31:0];
                end
            end
        endcase
`ifdef FAIRY_MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            mb = (op == 2'd0 && b[31]) ? -b : b;
            bl = 0;
            for (int i = 0; i < 32; i++) if (mb[i]) bl = i + 1;
            lat = 2 + ((bl < 1) ? 1 : bl);
        end
`endif
    endfunction

    // Model advances on each rising edge from the inputs presented in that cycle
    always @(posedge clk) begin
        logic [31:0] th, tl;
        logic        td;
        int          tlat;
        if (reset) begin
            m_busy = 0; m_valid = 0; m_hi = '0; m_lo = '0; m_dbz = 0; m_left = 0;
        end else if (flush_i) begin
            m_busy = 0; m_valid = 0; m_left = 0;
        end else begin
            m_valid = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_valid = 1;
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
                end
            end else if (start_i) begin
                model_op(op_i, a_i, b_i, th, tl, td, tlat);
                p_hi = th; p_lo = tl; p_dbz = td;
                m_busy = 1; m_left = tlat - 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_o", 64'(busy_o), 64'(m_busy));
            chk("valid_o", 64'(valid_o), 64'(m_valid));
            chk("hi_o", 64'(hi_o), 64'(m_hi));
            chk("lo_o", 64'(lo_o), 64'(m_lo));
            chk("div_by_zero_o", 64'(div_by_zero_o), 64'(m_dbz));
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Launch one op from idle and check literal results and latency
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input int elat);
        int n;
        bit got;
        got = 0;
        n = 0;
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(negedge clk);
            if (i == 1) start_i = 1'b0;
            if (valid_o) begin got = 1; n = i; end
        end
        if (!got) begin
            n_vec++; n_fail++;
            $display("FAIL %s: valid_o timeout", name);
        end else begin
            chk({name, " latency"}, 64'(n), 64'(elat));
            chk({name, " hi"}, 64'(hi_o), 64'(ehi));
            chk({name, " lo"}, 64'(lo_o), 64'(elo));
            chk({name, " dbz"}, 64'(div_by_zero_o), 64'(edbz));
        end
    endtask

    int  mul_lat;
    int  vcount;
    bit  seen34, seen68;

    initial begin
        reset = 1'b1; flush_i = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
`ifdef FAIRY_MULDIV_EARLY_OUT_EN
        mul_lat = 5;
`else
        mul_lat = 34;
`endif
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset hi", 64'(hi_o), 64'd0);
        chk("reset lo", 64'(lo_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult -1*7", 2'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, mul_lat);
        run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("divu 100/0", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 34);
        run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);

        // Flush in the middle of a divide
        op_i = 2'd3; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start_i = 1'b0;
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush busy", 64'(busy_o), 64'd0);
        chk("flush hi hold", 64'(hi_o), 64'd0);
        chk("flush lo hold", 64'(lo_o), 64'h8000_0000);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) vcount++;
        end
        chk("flush no valid", 64'(vcount), 64'd0);
        run_op("divu after flush", 2'd3, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 34);

        // Back-to-back: ignored start while busy, start accepted in the DONE cycle
        seen34 = 0; seen68 = 0;
        op_i = 2'd3; a_i = 32'd50; b_i = 32'd7; start_i = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (i == 5) begin op_i = 2'd0; a_i = 32'd3; b_i = 32'd3; start_i = 1'b1; end
            if (i == 34) begin
                seen34 = valid_o;
                chk("b2b first lo", 64'(lo_o), 64'd7);
                chk("b2b first hi", 64'(hi_o), 64'd1);
                op_i = 2'd3; a_i = 32'd81; b_i = 32'd9; start_i = 1'b1;
            end
            if (i == 68) begin
                seen68 = valid_o;
                chk("b2b second lo", 64'(lo_o), 64'd9);
                chk("b2b second hi", 64'(hi_o), 64'd0);
            end
        end
        chk("b2b valid at 34", 64'(seen34), 64'd1);
        chk("b2b valid at 68", 64'(seen68), 64'd1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 2500; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            flush_i = ($urandom_range(0, 39) == 0);
            start_i = ($urandom_range(0, 2) == 0);
            op_i    = 2'($urandom_range(0, 3));
            a_i     = pick();
            b_i     = pick();
            @(negedge clk);
        end
        reset = 1'b0; flush_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 40; i++) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
